// File: rtl/id_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_stream_pkg
// Description : Shared types, constants and helpers for the BCD ID digit
//               streamer. ST_CSUM exists only when ID_STREAM_CHECKSUM_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package id_stream_pkg;

`ifdef ID_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
`endif

  // Largest legal BCD nibble value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Digit index counter covers indexes 0..MAX_DIGITS-1
  localparam int MAX_DIGITS  = 16;
  localparam int DIGIT_IDX_W = $clog2(MAX_DIGITS);

  // Gap counter covers gap lengths up to MAX_GAP_CYCLES
  localparam int MAX_GAP_CYCLES = 255;
  localparam int GAP_CNT_W      = $clog2(MAX_GAP_CYCLES + 1);

  // Illegal BCD nibbles are replaced by zero on the output
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
    return (nib > BCD_MAX) ? 4'd0 : nib;
  endfunction

  // Running checksum: (acc + d) mod 10, both operands already in 0..9
  function automatic logic [3:0] add_mod10(input logic [3:0] acc,
                                           input logic [3:0] d);
    logic [4:0] s;
    s = {1'b0, acc} + {1'b0, d};
    if (s > 5'd9) s = s - 5'd10;
    return s[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_parity_gen.sv
`default_nettype none
// ============================================================================
// Module      : id_parity_gen
// Description : Combinational parity for one 4-bit digit. o_even makes the
//               digit plus parity bit carry an even number of ones.
// Revision    : 1.0 - initial release
// ============================================================================
module id_parity_gen (
  input  logic [3:0] i_digit,
  output logic       o_even,
  output logic       o_odd
);

  assign o_even = ^i_digit;
  assign o_odd  = ~o_even;

endmodule
`default_nettype wire

// File: rtl/id_digit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : id_digit_streamer
// Description : Captures a packed BCD ID on start and streams it MSD first,
//               one digit per valid/ready handshake, with GAP_CYCLES idle
//               cycles between digits. Define ID_STREAM_CHECKSUM_EN to append
//               a mod-10 checksum digit after digit index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module id_digit_streamer
  import id_stream_pkg::*;
#(
  parameter int NUM_DIGITS = 7,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] id_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_digit,
  output logic                    out_even_parity,
  output logic                    out_odd_parity,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    bcd_error
);

  localparam int                     SHIFT_W    = 4 * NUM_DIGITS;
  localparam logic [DIGIT_IDX_W-1:0] c_last_idx = DIGIT_IDX_W'(NUM_DIGITS - 1);
  localparam logic [GAP_CNT_W-1:0]   c_gap_load = (GAP_CYCLES > 0) ?
                                                  GAP_CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit                     c_has_gap  = (GAP_CYCLES > 0);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [SHIFT_W-1:0]       r_shift;
  logic [DIGIT_IDX_W-1:0]   r_idx;
  logic [GAP_CNT_W-1:0]     r_gap;
  logic                     r_err;
  logic                     r_done;
  logic                     w_load;
  logic                     w_digit_xfer;
  logic                     w_final_xfer;
  logic [3:0]               w_top_nib;
  logic [3:0]               w_send_digit;
  logic                     w_even;
  logic                     w_odd;
`ifdef ID_STREAM_CHECKSUM_EN
  logic [3:0]               r_sum;
  logic                     r_to_csum;
`endif

  assign w_top_nib    = r_shift[SHIFT_W-1 -: 4];
  assign w_send_digit = bcd_sanitize(w_top_nib);
  assign w_digit_xfer = (r_state == ST_SEND) && out_ready;

`ifdef ID_STREAM_CHECKSUM_EN
  assign out_valid    = (r_state == ST_SEND) || (r_state == ST_CSUM);
  assign out_last     = (r_state == ST_CSUM);
  assign w_final_xfer = (r_state == ST_CSUM) && out_ready;
  assign out_digit    = (r_state == ST_SEND) ? w_send_digit :
                        (r_state == ST_CSUM) ? r_sum : 4'd0;
`else
  assign out_valid    = (r_state == ST_SEND);
  assign out_last     = (r_state == ST_SEND) && (r_idx == '0);
  assign w_final_xfer = w_digit_xfer && (r_idx == '0);
  assign out_digit    = (r_state == ST_SEND) ? w_send_digit : 4'd0;
`endif

  id_parity_gen u_parity (
    .i_digit (out_digit),
    .o_even  (w_even),
    .o_odd   (w_odd)
  );

  // Parity outputs read zero whenever no digit is being presented
  assign out_even_parity = out_valid & w_even;
  assign out_odd_parity  = out_valid & w_odd;
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;
  assign bcd_error       = r_err;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode: handshake moves SEND forward, gap counter ends GAP
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
`ifdef ID_STREAM_CHECKSUM_EN
          if (c_has_gap)           w_next_state = ST_GAP;
          else if (r_idx == '0)    w_next_state = ST_CSUM;
          else                     w_next_state = ST_SEND;
`else
          if (r_idx == '0)         w_next_state = ST_IDLE;
          else if (c_has_gap)      w_next_state = ST_GAP;
          else                     w_next_state = ST_SEND;
`endif
        end
      end
      ST_GAP: begin
        if (r_gap == '0) begin
`ifdef ID_STREAM_CHECKSUM_EN
          w_next_state = r_to_csum ? ST_CSUM : ST_SEND;
`else
          w_next_state = ST_SEND;
`endif
        end
      end
`ifdef ID_STREAM_CHECKSUM_EN
      ST_CSUM: begin
        if (out_ready) w_next_state = ST_IDLE;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Digit shift register, index counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_shift <= id_bcd;
      r_idx   <= c_last_idx;
      r_err   <= 1'b0;
    end else if (w_digit_xfer) begin
      r_shift <= r_shift << 4;
      r_idx   <= r_idx - DIGIT_IDX_W'(1);
      if (w_top_nib > BCD_MAX) r_err <= 1'b1;
    end
  end

`ifdef ID_STREAM_CHECKSUM_EN
  // Checksum accumulates emitted (sanitized) digits; flag steers GAP to CSUM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum     <= 4'd0;
      r_to_csum <= 1'b0;
    end else if (w_load) begin
      r_sum     <= 4'd0;
      r_to_csum <= 1'b0;
    end else if (w_digit_xfer) begin
      r_sum <= add_mod10(r_sum, w_send_digit);
      if (r_idx == '0) r_to_csum <= 1'b1;
    end
  end
`endif

  // Gap counter loads on entry to GAP and counts down to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap <= '0;
    end else if ((w_next_state == ST_GAP) && (r_state != ST_GAP)) begin
      r_gap <= c_gap_load;
    end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
      r_gap <= r_gap - GAP_CNT_W'(1);
    end
  end

  // One-cycle done pulse following the final transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_final_xfer;
  end

endmodule
`default_nettype wire

// File: tb/tb_id_digit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_digit_streamer
// Description : Self-checking bench for id_digit_streamer (NUM_DIGITS=7,
//               GAP_CYCLES=2). Expected digit streams are computed from the
//               ID with plain arithmetic; honours ID_STREAM_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_digit_streamer;

  localparam int N   = 7;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [4*N-1:0] id_bcd;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_digit;
  logic           out_even_parity;
  logic           out_odd_parity;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           bcd_error;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int exp_d[$];
  bit exp_bad[$];
  bit last_err = 1'b0;

  always #5 clk = ~clk;

  id_digit_streamer #(.NUM_DIGITS(N), .GAP_CYCLES(GAP)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .id_bcd          (id_bcd),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_digit       (out_digit),
    .out_even_parity (out_even_parity),
    .out_odd_parity  (out_odd_parity),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done),
    .bcd_error       (bcd_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: digits MSD first, illegal nibbles become 0, optional mod-10 sum
  task automatic build_model(input logic [4*N-1:0] id);
    int sum;
    logic [3:0] nib;
    exp_d.delete();
    exp_bad.delete();
    sum = 0;
    for (int i = N - 1; i >= 0; i--) begin
      nib = id[4*i +: 4];
      exp_d.push_back((nib > 4'd9) ? 0 : int'(nib));
      exp_bad.push_back(nib > 4'd9);
      sum += (nib > 4'd9) ? 0 : int'(nib);
    end
`ifdef ID_STREAM_CHECKSUM_EN
    exp_d.push_back(sum % 10);
    exp_bad.push_back(1'b0);
`endif
  endtask

  function automatic logic [4*N-1:0] rand_id();
    logic [4*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
      else                           r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_digit"}, out_digit, 0);
    chk({tag, "_even"},  out_even_parity, 0);
    chk({tag, "_odd"},   out_odd_parity, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   bcd_error, 0);
  endtask

  // mode 0: ready always high; 1: random ready and stray starts;
  // 2: ready low 5 cycles on the third digit plus stray starts.
  // abort_at >= 0 asserts reset while that digit index is presented.
  task automatic run_id(input logic [4*N-1:0] id, input int mode, input int abort_at);
    int n, k, gap_left, cycles, stall;
    bit err_seen, xfer, rdy;
    logic [3:0] dv;
    build_model(id);
    n = exp_d.size();
    chk("idle_valid", out_valid, 0);
    chk("idle_err_hold", bcd_error, last_err);
    start     = 1'b1;
    id_bcd    = id;
    out_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    id_bcd = (4*N)'($urandom);
    k = 0; gap_left = 0; cycles = 0; stall = 0; err_seen = 1'b0;
    while (k < n) begin
      if (cycles > 2000) begin
        checks++;
        fails++;
        $error("FAIL stream_timeout observed=%0d expected<=%0d", cycles, 2000);
        break;
      end
      if (abort_at >= 0 && k == abort_at && gap_left == 0) begin
        start = 1'b0;
        #1 reset = 1'b1;
        #1 chk_all_zero("abort");
        #1 reset = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
        end
        last_err = 1'b0;
        return;
      end
      chk("busy", busy, 1);
      xfer = 1'b0;
      if (gap_left > 0) begin
        chk("gap_valid", out_valid, 0);
        gap_left--;
        rdy = 1'($urandom_range(0, 1));
      end else begin
        dv = 4'(exp_d[k]);
        chk("valid", out_valid, 1);
        chk("digit", out_digit, dv);
        chk("even", out_even_parity, ^dv);
        chk("odd", out_odd_parity, ~^dv);
        chk("last", out_last, (k == n - 1));
        chk("err", bcd_error, err_seen);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 9) < 6);
          default: begin
            if (k == 2 && stall < 5) begin
              rdy = 1'b0;
              stall++;
            end else rdy = 1'b1;
          end
        endcase
        xfer = rdy;
      end
      out_ready = rdy;
      start     = (mode != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      id_bcd    = (4*N)'($urandom);
      if (xfer) begin
        if (exp_bad[k]) err_seen = 1'b1;
        k++;
        gap_left = (k < n) ? GAP : 0;
      end
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_drop", busy, 0);
    chk("post_valid", out_valid, 0);
    chk("err_final", bcd_error, err_seen);
    if (mode == 0) chk("stream_cycles", cycles, n + (n - 1) * GAP);
    @(negedge clk);
    chk("done_single", done, 0);
    last_err = err_seen;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    id_bcd    = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_id(28'h2147471, 0, -1);
    run_id(28'h2147471, 2, -1);
    run_id(28'h21A7471, 0, -1);
    run_id(28'h1234567, 0, 4);
    run_id(28'h9876543, 0, -1);
    for (int i = 0; i < 12; i++) run_id(rand_id(), 1, -1);
    run_id(28'hFFFFFFF, 1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
